// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory loader:
//   - imem_state_e  : controller states (IDLE, LOAD, RUN)
//   - NOP_WORD      : fill / error word (addi x0,x0,0)
//   - decode_fetch(): word index plus alignment/range check for a byte address
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  typedef struct packed {
    logic        err;       // misaligned or beyond the end of memory
    logic [29:0] word_idx;  // byte address divided by four
  } fetch_decode_t;

  // The range test is done on 33 bits so that a memory filling the whole
  // 32-bit address space cannot overflow the limit computation.
  function automatic fetch_decode_t decode_fetch(input logic [31:0] addr,
                                                 input int unsigned num_words);
    fetch_decode_t r;
    logic [32:0]   limit;
    limit      = 33'(num_words) << 2;
    r.word_idx = addr[31:2];
    r.err      = (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles the byte-loader stream and the core fetch port of the instruction
// memory.
//   master : download source + core (drives load/byte/fetch requests)
//   slave  : instr_mem_loader (drives ready/overflow/busy and fetch response)
// Loader : load_start, ld_byte_valid, ld_byte[7:0], ld_last -> ld_byte_ready,
//          ld_overflow, busy
// Fetch  : fetch_req, fetch_addr[31:0] -> fetch_valid, fetch_instr[31:0],
//          fetch_err
// ---------------------------------------------------------------------------
interface instr_mem_loader_if;

  logic        load_start;
  logic        ld_byte_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_byte_ready;
  logic        ld_overflow;
  logic        busy;

  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;

  modport master (
    output load_start, ld_byte_valid, ld_byte, ld_last, fetch_req, fetch_addr,
    input  ld_byte_ready, ld_overflow, busy, fetch_valid, fetch_instr, fetch_err
  );

  modport slave (
    input  load_start, ld_byte_valid, ld_byte, ld_last, fetch_req, fetch_addr,
    output ld_byte_ready, ld_overflow, busy, fetch_valid, fetch_instr, fetch_err
  );

endinterface

// File: rtl/instr_mem_loader_ld_byte_assembler.sv
// ---------------------------------------------------------------------------
// ld_byte_assembler
// Packs a little-endian byte stream into 32-bit words.
//   clk, n_rst        : clock, asynchronous active-low reset
//   clear_i           : drop any partial word and restart at byte 0
//   accept_i          : a byte is taken this cycle
//   byte_i[7:0]       : the byte being taken
//   last_i            : the byte being taken is the final one of the stream
//   word_done_o       : fourth byte taken; word_o is a complete word
//   partial_flush_o   : last byte taken before the word filled; word_o holds
//                       the partial word with unfilled upper bytes zero
//   word_o[31:0]      : assembled word including the byte being taken
// ---------------------------------------------------------------------------
module ld_byte_assembler (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  input  logic        last_i,
  output logic        word_done_o,
  output logic        partial_flush_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;

  // Lane gi takes the incoming byte when it is the current slot; other lanes
  // come from the register. Lanes above the current slot are always zero
  // because asm_q is cleared after every word, which gives the zero padding
  // of a partial flush for free.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_o[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? byte_i : asm_q[8*gi +: 8];
    end
  endgenerate

  assign word_done_o     = accept_i && (byte_cnt_q == 2'd3);
  assign partial_flush_o = accept_i && last_i && (byte_cnt_q != 2'd3);

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear_i) begin
      byte_cnt_d = 2'd0;
      asm_d      = 32'h0;
    end else if (accept_i) begin
      if (word_done_o || last_i) begin
        byte_cnt_d = 2'd0;
        asm_d      = 32'h0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        asm_d      = word_o;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'h0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Instruction memory for the single-cycle RV32I core with a byte-serial
// program loader in front of it.
//   clk, n_rst : clock, asynchronous active-low reset (memory refills NOPs)
//   bus        : instr_mem_loader_if.slave
//                loader side  - load_start, ld_byte_valid, ld_byte, ld_last
//                               -> ld_byte_ready, ld_overflow, busy
//                fetch side   - fetch_req, fetch_addr
//                               -> fetch_valid, fetch_instr, fetch_err
// Parameter NUM_WORDS: memory depth in words, power of two, >= 4.
// ---------------------------------------------------------------------------
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  instr_mem_loader_if.slave  bus
);

  localparam int unsigned      ADDR_W   = $clog2(NUM_WORDS);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(NUM_WORDS);

  imem_state_e       state_q;
  logic              ld_byte_ready_q;
  logic              ld_overflow_q;
  logic              busy_q;
  logic              fetch_valid_q;
  logic              fetch_err_q;
  logic [31:0]       fetch_instr_q;
  logic [ADDR_W:0]   word_cnt_q;

  logic [31:0]       mem_q [NUM_WORDS];

  logic              byte_accept;
  logic              word_done;
  logic              partial_flush;
  logic              mem_full;
  logic              mem_we;
  logic [31:0]       asm_word;
  fetch_decode_t     fetch_dec;
  logic              unused_idx_hi;

  // load_start has priority over a byte offered in the same cycle: the load
  // restarts and that byte is not taken.
  assign byte_accept = bus.ld_byte_valid && ld_byte_ready_q && !bus.load_start;
  assign mem_full    = (word_cnt_q == FULL_CNT);
  assign mem_we      = (word_done || partial_flush) && !mem_full;
  assign fetch_dec   = decode_fetch(bus.fetch_addr, NUM_WORDS);

  // Index bits above the memory depth only matter to the range check.
  assign unused_idx_hi = ^fetch_dec.word_idx[29:ADDR_W];

  ld_byte_assembler u_asm (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear_i         (bus.load_start),
    .accept_i        (byte_accept),
    .byte_i          (bus.ld_byte),
    .last_i          (bus.ld_last),
    .word_done_o     (word_done),
    .partial_flush_o (partial_flush),
    .word_o          (asm_word)
  );

  // Program storage. Reset refills every word with NOP so that a short
  // download followed by a stray fetch executes harmless instructions.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (mem_we) begin
      mem_q[word_cnt_q[ADDR_W-1:0]] <= asm_word;
    end
  end

  // Controller with registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      ld_byte_ready_q <= 1'b0;
      ld_overflow_q   <= 1'b0;
      busy_q          <= 1'b1;
      fetch_valid_q   <= 1'b0;
      fetch_instr_q   <= NOP_WORD;
      fetch_err_q     <= 1'b0;
      word_cnt_q      <= '0;
    end else begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      if (bus.load_start) begin
        // Entering LOAD from any state, including a restart mid-load.
        // A fetch requested in the same cycle gets no response.
        state_q         <= LOAD;
        ld_byte_ready_q <= 1'b1;
        busy_q          <= 1'b1;
        ld_overflow_q   <= 1'b0;
        word_cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
          end
          LOAD: begin
            if (byte_accept) begin
              if (word_done || partial_flush) begin
                if (mem_full) begin
                  ld_overflow_q <= 1'b1;
                end else begin
                  word_cnt_q <= word_cnt_q + 1'b1;
                end
              end
              if (bus.ld_last) begin
                state_q         <= RUN;
                ld_byte_ready_q <= 1'b0;
                busy_q          <= 1'b0;
              end
            end
          end
          RUN: begin
            if (bus.fetch_req) begin
              fetch_valid_q <= 1'b1;
              fetch_err_q   <= fetch_dec.err;
              fetch_instr_q <= fetch_dec.err ? NOP_WORD
                                             : mem_q[fetch_dec.word_idx[ADDR_W-1:0]];
            end
          end
          default: begin
            state_q         <= IDLE;
            ld_byte_ready_q <= 1'b0;
            busy_q          <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ld_byte_ready = ld_byte_ready_q;
  assign bus.ld_overflow   = ld_overflow_q;
  assign bus.busy          = busy_q;
  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.fetch_instr   = fetch_instr_q;
  assign bus.fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
// Two instances: u_dut64 (NUM_WORDS=64) and u_dut4 (NUM_WORDS=4, overflow).
// A byte-queue model predicts memory contents when a download ends and the
// fetch response of every RUN cycle; one negedge process compares both DUTs
// against it every cycle, and literal checks pin the model to known words.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic n_rst;

  instr_mem_loader_if if_a ();
  instr_mem_loader_if if_b ();

  instr_mem_loader #(.NUM_WORDS(64)) u_dut64 (.clk(clk), .n_rst(n_rst), .bus(if_a));
  instr_mem_loader #(.NUM_WORDS(4))  u_dut4  (.clk(clk), .n_rst(n_rst), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- model state (index 0: 64-word DUT, 1: 4-word DUT) -------
  int          m_mode  [2];        // 0 idle, 1 load, 2 run
  logic [31:0] m_mem   [2][64];
  logic [7:0]  m_buf   [2][128];
  int          m_n     [2];
  logic        m_ovf   [2];
  logic        m_valid [2];
  logic        m_err   [2];
  logic [31:0] m_instr [2];

  function automatic int nw(input int d);
    return (d == 0) ? 64 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_n[d] = 0; m_ovf[d] = 1'b0;
      m_valid[d] = 1'b0; m_err[d] = 1'b0; m_instr[d] = NOP;
      for (int w = 0; w < 64; w++) m_mem[d][w] = NOP;
    end
  endtask

  // At the end of a download the byte queue is cut into little-endian words.
  task automatic model_commit(input int d);
    int nwords;
    logic [31:0] word;
    nwords = (m_n[d] + 3) / 4;
    for (int w = 0; w < nwords; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < m_n[d]) word = word | (32'(m_buf[d][4 * w + k]) << (8 * k));
      if (w < nw(d)) m_mem[d][w] = word;
      else m_ovf[d] = 1'b1;
    end
  endtask

  task automatic model_step(input int d, input logic ls, input logic bv, input logic [7:0] b,
                            input logic last, input logic fr, input logic [31:0] a);
    m_valid[d] = 1'b0;
    m_err[d]   = 1'b0;
    if (ls) begin
      m_mode[d] = 1; m_n[d] = 0; m_ovf[d] = 1'b0;
    end else if (m_mode[d] == 1 && bv) begin
      if (m_n[d] < 128) m_buf[d][m_n[d]] = b;
      m_n[d]++;
      if (last) begin
        model_commit(d);
        m_mode[d] = 2;
      end
    end else if (m_mode[d] == 2 && fr) begin
      m_valid[d] = 1'b1;
      if (a[1:0] != 2'b00 || longint'(a) >= longint'(4 * nw(d))) begin
        m_err[d]   = 1'b1;
        m_instr[d] = NOP;
      end else begin
        m_instr[d] = m_mem[d][a / 4];
      end
    end
  endtask

  always @(posedge clk) begin
    if (n_rst) begin
      model_step(0, if_a.load_start, if_a.ld_byte_valid, if_a.ld_byte, if_a.ld_last,
                 if_a.fetch_req, if_a.fetch_addr);
      model_step(1, if_b.load_start, if_b.ld_byte_valid, if_b.ld_byte, if_b.ld_last,
                 if_b.fetch_req, if_b.fetch_addr);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic busy, input logic rdy, input logic ovf,
                         input logic vld, input logic [31:0] ins, input logic err);
    chk($sformatf("busy[%0d]", d),        32'(busy), 32'(m_mode[d] != 2));
    chk($sformatf("ready[%0d]", d),       32'(rdy),  32'(m_mode[d] == 1));
    chk($sformatf("fetch_valid[%0d]", d), 32'(vld),  32'(m_valid[d]));
    chk($sformatf("fetch_err[%0d]", d),   32'(err),  32'(m_err[d]));
    chk($sformatf("fetch_instr[%0d]", d), ins,       m_instr[d]);
    if (m_mode[d] != 1) chk($sformatf("overflow[%0d]", d), 32'(ovf), 32'(m_ovf[d]));
  endtask

  always @(negedge clk) begin
    cmp_dut(0, if_a.busy, if_a.ld_byte_ready, if_a.ld_overflow,
            if_a.fetch_valid, if_a.fetch_instr, if_a.fetch_err);
    cmp_dut(1, if_b.busy, if_b.ld_byte_ready, if_b.ld_overflow,
            if_b.fetch_valid, if_b.fetch_instr, if_b.fetch_err);
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input int d, input logic ls, input logic bv, input logic [7:0] b,
                        input logic last, input logic fr, input logic [31:0] a);
    if_a.load_start    = (d == 0) && ls;
    if_a.ld_byte_valid = (d == 0) && bv;
    if_a.ld_byte       = (d == 0) ? b : 8'h00;
    if_a.ld_last       = (d == 0) && last;
    if_a.fetch_req     = (d == 0) && fr;
    if_a.fetch_addr    = (d == 0) ? a : 32'h0;
    if_b.load_start    = (d == 1) && ls;
    if_b.ld_byte_valid = (d == 1) && bv;
    if_b.ld_byte       = (d == 1) ? b : 8'h00;
    if_b.ld_last       = (d == 1) && last;
    if_b.fetch_req     = (d == 1) && fr;
    if_b.fetch_addr    = (d == 1) ? a : 32'h0;
  endtask

  // One cycle: inputs applied at a negedge, returns at the following negedge.
  task automatic drive(input int d, input logic ls, input logic bv, input logic [7:0] b,
                       input logic last, input logic fr, input logic [31:0] a);
    set_in(d, ls, bv, b, last, fr, a);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input int d, input logic [31:0] a);
    drive(d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a);
  endtask

  logic [7:0]  prog1 [8]  = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
  logic [7:0]  prog2 [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [31:0] b2b_addr [3] = '{32'h0, 32'h4, 32'h8};
  logic [31:0] b2b_word [3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0000_0013};

  initial begin
    n_rst = 1'b0;
    model_reset();
    set_in(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(if_a.busy), 32'd1);
    chk("reset_ready", 32'(if_a.ld_byte_ready), 32'd0);
    chk("reset_instr", if_a.fetch_instr, NOP);

    // Fetch while IDLE is ignored.
    fetch(0, 32'h0);
    chk("idle_fetch_valid", 32'(if_a.fetch_valid), 32'd0);

    // Two-word download.
    drive(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    chk("load_ready", 32'(if_a.ld_byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) drive(0, 1'b0, 1'b1, prog1[i], i == 7, 1'b0, 32'h0);
    chk("run_busy", 32'(if_a.busy), 32'd0);
    fetch(0, 32'h4);
    chk("word1_valid", 32'(if_a.fetch_valid), 32'd1);
    chk("word1", if_a.fetch_instr, 32'h00A0_0113);
    fetch(0, 32'h0);
    chk("word0", if_a.fetch_instr, 32'h0050_0093);
    fetch(0, 32'h14);
    chk("word5_nop", if_a.fetch_instr, NOP);

    // Error fetches.
    fetch(0, 32'h2);
    chk("misalign_err", 32'(if_a.fetch_err), 32'd1);
    chk("misalign_instr", if_a.fetch_instr, NOP);
    fetch(0, 32'h100);
    chk("range_err", 32'(if_a.fetch_err), 32'd1);
    fetch(0, 32'hFC);
    chk("last_word_ok", 32'(if_a.fetch_err), 32'd0);

    // Back-to-back fetches.
    for (int i = 0; i < 3; i++) begin
      fetch(0, b2b_addr[i]);
      chk($sformatf("b2b_valid%0d", i), 32'(if_a.fetch_valid), 32'd1);
      chk($sformatf("b2b_word%0d", i), if_a.fetch_instr, b2b_word[i]);
    end

    // load_start with fetch_req: no response, back to busy.
    drive(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4);
    chk("ls_fetch_valid", 32'(if_a.fetch_valid), 32'd0);
    chk("ls_fetch_busy", 32'(if_a.busy), 32'd1);

    // Partial last word, with a gap cycle mid-stream.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b0, 1'b1, prog2[i], i == 5, 1'b0, 32'h0);
      if (i == 2) drive(0, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 32'h0);
    end
    fetch(0, 32'h4);
    chk("partial_word", if_a.fetch_instr, 32'h0000_6655);
    fetch(0, 32'h0);
    chk("partial_word0", if_a.fetch_instr, 32'h4433_2211);
    drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    chk("hold_valid", 32'(if_a.fetch_valid), 32'd0);
    chk("hold_instr", if_a.fetch_instr, 32'h4433_2211);

    // Overflow on the 4-word instance.
    drive(1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) drive(1, 1'b0, 1'b1, 8'(i + 1), i == 19, 1'b0, 32'h0);
    chk("ovf_flag", 32'(if_b.ld_overflow), 32'd1);
    fetch(1, 32'h0);
    chk("ovf_word0", if_b.fetch_instr, 32'h0403_0201);
    fetch(1, 32'hC);
    chk("ovf_word3", if_b.fetch_instr, 32'h100F_0E0D);
    fetch(1, 32'h10);
    chk("ovf_range_err", 32'(if_b.fetch_err), 32'd1);

    // Reset in the middle of a download.
    drive(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 32'h0);
    set_in(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    #2 n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_busy", 32'(if_a.busy), 32'd1);
    chk("midrst_ready", 32'(if_a.ld_byte_ready), 32'd0);
    chk("midrst_ovf4", 32'(if_b.ld_overflow), 32'd0);
    #2 n_rst = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b1, 8'hDD, 1'b1, 1'b0, 32'h0);
    fetch(0, 32'h0);
    chk("after_rst_word0", if_a.fetch_instr, 32'hDDCC_BBAA);
    fetch(0, 32'h4);
    chk("after_rst_word1_nop", if_a.fetch_instr, NOP);
    drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
